mcpu_ctrl: RTL

Multi-cycle MIPS control unit for the `mcpu` datapath. It sits directly upstream of the ALU and drives its 3-bit `ALU_operation` code, along with every datapath mux select and write enable. It sequences each instruction through a Moore state machine, stalling on memory handshakes. It consumes the ALU `zero` and `overflow` flags for branches and the optional overflow trap.

---
 rtl/mcpu_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl -- multi-cycle MIPS control unit for the mcpu datapath.
//
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback. It drives every datapath mux select, the write enables and
// the 3-bit ALU operation code. In IF, MEM_RD and MEM_WR it stalls until
// MIO_ready is high.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   Inst_in[31:0]   IR contents (opcode [31:26], funct [5:0])
//   zero, overflow  ALU flags used for branches and the overflow trap
//   MIO_ready       the memory transfer completes this cycle
//   MemRead/MemWrite/IorD/IRWrite/RegWrite/RegDst/MemtoReg/ALUSrcA/ALUSrcB/
//   imm_zext/ALU_operation/PCSource/pc_en
//                   datapath controls
//   state_out[3:0]  current state code, for debug
//
// Configuration
//   OVERFLOW_TRAP_EN  when defined, R_WB and I_WB drop RegWrite if the
//                     add/sub in the preceding execute state overflowed.
// -----------------------------------------------------------------------------
module mcpu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        imm_zext,
    output logic [2:0]  ALU_operation,
    output logic [1:0]  PCSource,
    output logic        pc_en,
    output logic [3:0]  state_out
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LW_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_J        = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12,
        S_I_EXE    = 4'd13,
        S_I_WB     = 4'd14,
        S_LUI_WB   = 4'd15
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] opcode, funct;
    logic [2:0] r_op, i_op;
    logic       r_legal, i_zext;
    logic       wb_en;

    assign opcode    = Inst_in[31:26];
    assign funct     = Inst_in[5:0];
    assign state_out = state_q;

    // R-type funct decode; an unknown funct abandons the instruction.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        r_op    = 3'd2;
        r_legal = 1'b1;
        case (funct)
            6'b100000: r_op = 3'd2;
            6'b100010: r_op = 3'd6;
            6'b100100: r_op = 3'd0;
            6'b100101: r_op = 3'd1;
            6'b100110: r_op = 3'd3;
            6'b100111: r_op = 3'd4;
            6'b101010: r_op = 3'd7;
            6'b000010: r_op = 3'd5;
            default:   r_legal = 1'b0;
        endcase
    end

    // I-type opcode decode; logical immediates are zero-extended.
    always_comb begin
        i_op   = 3'd2;
        i_zext = 1'b0;
        case (opcode)
            6'b001100: begin i_op = 3'd0; i_zext = 1'b1; end
            6'b001101: begin i_op = 3'd1; i_zext = 1'b1; end
            6'b001110: begin i_op = 3'd3; i_zext = 1'b1; end
            6'b001010: i_op = 3'd7;
            default:   i_op = 3'd2;
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    logic ovf_q, ovf_d;

    // Only add/sub can trap; any other execute op clears the flag.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_R_EXE)
            ovf_d = overflow & ((r_op == 3'd2) | (r_op == 3'd6));
        else if (state_q == S_I_EXE)
            ovf_d = overflow & ((i_op == 3'd2) | (i_op == 3'd6));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign wb_en = ~ovf_q;

    // Jump-target and register fields are consumed by the datapath, not here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^Inst_in[25:6];
`else
    assign wb_en = 1'b1;

    logic unused_inst_bits;
    assign unused_inst_bits = ^{Inst_in[25:6], overflow};
`endif

    // NOTE: state flops use non-blocking assignment; all decode lives in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        imm_zext      = 1'b0;
        ALU_operation = 3'd0;
        PCSource      = 2'b00;
        pc_en         = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = 3'd2;
                IRWrite       = MIO_ready;
                pc_en         = MIO_ready;
                if (MIO_ready) state_d = S_ID;
            end
            S_ID: begin
                ALUSrcB       = 2'b11;
                ALU_operation = 3'd2;
                case (opcode)
                    6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_R_EXE;
                    6'b100011,
                    6'b101011: state_d = S_MEM_ADDR;
                    6'b000100: state_d = S_BEQ;
                    6'b000101: state_d = S_BNE;
                    6'b000010: state_d = S_J;
                    6'b000011: state_d = S_JAL;
                    6'b001000, 6'b001100, 6'b001101,
                    6'b001110, 6'b001010: state_d = S_I_EXE;
                    6'b001111: state_d = S_LUI_WB;
                    default:   state_d = S_IF;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = 3'd2;
                state_d       = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MIO_ready) state_d = S_LW_WB;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_IF;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MIO_ready) state_d = S_IF;
            end
            S_R_EXE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = r_op;
                state_d       = r_legal ? S_R_WB : S_IF;
            end
            S_R_WB: begin
                RegWrite = wb_en;
                RegDst   = 2'b01;
                state_d  = S_IF;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = 3'd6;
                PCSource      = 2'b01;
                pc_en         = (state_q == S_BEQ) ? zero : ~zero;
                state_d       = S_IF;
            end
            S_J: begin
                PCSource = 2'b10;
                pc_en    = 1'b1;
                state_d  = S_IF;
            end
            S_JAL: begin
                PCSource = 2'b10;
                pc_en    = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                state_d  = S_IF;
            end
            S_JR: begin
                PCSource = 2'b11;
                pc_en    = 1'b1;
                state_d  = S_IF;
            end
            S_I_EXE: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = i_op;
                imm_zext      = i_zext;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = wb_en;
                state_d  = S_IF;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b11;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule
